// File: rtl/pong_pkg.sv
// Shared encodings for the pong game-flow blocks.
// Holds state codes, serve directions and the point-counter width.
package pong_pkg;

    typedef enum logic [2:0] {
        S_ATTRACT = 3'd0,
        S_SERVE   = 3'd1,
        S_PLAY    = 3'd2,
        S_PAUSE   = 3'd3,
        S_POINT   = 3'd4,
        S_OVER    = 3'd5
    } state_t;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    localparam int PTS_W = 7;

endpackage

// File: rtl/btn_edge.sv
// Push-button front end: 2-flop synchroniser plus registered rising-edge pulse.
// Ports: clk, reset (async high), in (raw button), rise (one-clk event).
module btn_edge (
    input  logic clk,
    input  logic reset,
    input  logic in,
    output logic rise
);

    logic s1, s2, prev;
    logic v1, v2;
    logic armed;

    // v1/v2 mark when s2 carries a real sample rather than its reset value.
    // Edges are only reported once a low level has been seen, so a button
    // held through reset release does not fire.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1    <= 1'b0;
            s2    <= 1'b0;
            prev  <= 1'b0;
            v1    <= 1'b0;
            v2    <= 1'b0;
            armed <= 1'b0;
            rise  <= 1'b0;
        end else begin
            s1   <= in;
            s2   <= s1;
            prev <= s2;
            v1   <= 1'b1;
            v2   <= v1;
            if (v2 && !s2)
                armed <= 1'b1;
            rise <= s2 & ~prev & armed;
        end
    end

endmodule

// File: rtl/match_ctrl.sv
// Pong game-flow sequencer: serve timing, pause, scoring pulses, game over.
// Ports: clk, reset, tick, start_btn, miss_left/right in; ball/score ctrl out.
module match_ctrl
    import pong_pkg::*;
#(
    parameter int SERVE_TICKS = 50,
    parameter int POINT_TICKS = 25,
    parameter int WIN_SCORE   = 11,
    parameter int TIMER_W     = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick,
    input  logic       start_btn,
    input  logic       miss_left,
    input  logic       miss_right,
    output logic       ball_run,
    output logic       ball_recenter,
    output logic       serve_dir,
    output logic       score_left_inc,
    output logic       score_right_inc,
    output logic       score_clear,
    output logic       game_over,
    output logic       winner,
    output logic [2:0] state_dbg
);

    localparam logic [TIMER_W-1:0] SERVE_LD = TIMER_W'(SERVE_TICKS);
    localparam logic [TIMER_W-1:0] POINT_LD = TIMER_W'(POINT_TICKS);
    localparam logic [TIMER_W-1:0] T_ONE    = TIMER_W'(1);
    localparam logic [PTS_W-1:0]   WIN_PTS  = PTS_W'(WIN_SCORE);
    localparam logic [PTS_W-1:0]   P_ONE    = PTS_W'(1);

    logic start_ev;

    btn_edge u_start (
        .clk   (clk),
        .reset (reset),
        .in    (start_btn),
        .rise  (start_ev)
    );

    state_t             state;
    logic [TIMER_W-1:0] timer;
    logic [PTS_W-1:0]   pts_left;
    logic [PTS_W-1:0]   pts_right;

    logic miss_l_only, miss_r_only, miss_both;
    logic expire, won_l, won_r;

    assign miss_l_only = miss_left & ~miss_right;
    assign miss_r_only = miss_right & ~miss_left;
    assign miss_both   = miss_left & miss_right;
    assign expire      = tick && (timer <= T_ONE);
    assign won_l       = (pts_left == WIN_PTS);
    assign won_r       = (pts_right == WIN_PTS);

    assign state_dbg = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state           <= S_ATTRACT;
            timer           <= '0;
            pts_left        <= '0;
            pts_right       <= '0;
            ball_run        <= 1'b0;
            ball_recenter   <= 1'b1;
            serve_dir       <= DIR_RIGHT;
            score_left_inc  <= 1'b0;
            score_right_inc <= 1'b0;
            score_clear     <= 1'b0;
            game_over       <= 1'b0;
            winner          <= 1'b0;
        end else begin
            score_left_inc  <= 1'b0;
            score_right_inc <= 1'b0;
            score_clear     <= 1'b0;
            unique case (1'b1)
                (state == S_ATTRACT),
                (state == S_OVER): begin
                    if (start_ev) begin
                        state         <= S_SERVE;
                        timer         <= SERVE_LD;
                        pts_left      <= '0;
                        pts_right     <= '0;
                        score_clear   <= 1'b1;
                        serve_dir     <= DIR_RIGHT;
                        game_over     <= 1'b0;
                        winner        <= 1'b0;
                        ball_run      <= 1'b0;
                        ball_recenter <= 1'b1;
                    end
                end
                (state == S_SERVE): begin
                    if (expire) begin
                        state         <= S_PLAY;
                        timer         <= '0;
                        ball_run      <= 1'b1;
                        ball_recenter <= 1'b0;
                    end else if (tick) begin
                        timer <= timer - T_ONE;
                    end
                end
                (state == S_PLAY): begin
                    if (miss_both) begin
                        state         <= S_SERVE;
                        timer         <= SERVE_LD;
                        ball_run      <= 1'b0;
                        ball_recenter <= 1'b1;
                    end else if (miss_l_only) begin
                        state           <= S_POINT;
                        timer           <= POINT_LD;
                        score_right_inc <= 1'b1;
                        serve_dir       <= DIR_LEFT;
                        ball_run        <= 1'b0;
                        if (!won_r)
                            pts_right <= pts_right + P_ONE;
                    end else if (miss_r_only) begin
                        state          <= S_POINT;
                        timer          <= POINT_LD;
                        score_left_inc <= 1'b1;
                        serve_dir      <= DIR_RIGHT;
                        ball_run       <= 1'b0;
                        if (!won_l)
                            pts_left <= pts_left + P_ONE;
                    end else if (start_ev) begin
                        state    <= S_PAUSE;
                        ball_run <= 1'b0;
                    end
                end
                (state == S_PAUSE): begin
                    if (start_ev) begin
                        state    <= S_PLAY;
                        ball_run <= 1'b1;
                    end
                end
                (state == S_POINT): begin
                    if (expire) begin
                        ball_recenter <= 1'b1;
                        if (won_l || won_r) begin
                            state     <= S_OVER;
                            game_over <= 1'b1;
                            winner    <= won_l;
                        end else begin
                            state <= S_SERVE;
                            timer <= SERVE_LD;
                        end
                    end else if (tick) begin
                        timer <= timer - T_ONE;
                    end
                end
                default: begin
                    state         <= S_ATTRACT;
                    timer         <= '0;
                    ball_run      <= 1'b0;
                    ball_recenter <= 1'b1;
                    game_over     <= 1'b0;
                    winner        <= 1'b0;
                end
            endcase
        end
    end

endmodule
